prio_irq_arbiter: RTL and testbench
===================================

# prio_irq_arbiter

Registered, parameterised N-input priority arbiter with pending latches, per-input masking and selectable fixed/round-robin priority. It is the sequential successor of the team's 8-to-3 combinational priority encoder. Requests are latched into a pending register and one winner is granted at a time. The grant is held stable until the consumer acknowledges it. The block sits between peripheral request lines and the interrupt/service sequencer of the experiment CPU.

## Interface
Parameters:
- `N`, default 8: number of request inputs; legal range 2..32, non-power-of-two allowed.
- `IDW`, default `$clog2(N)`: grant index width; derived, never overridden.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req`  in  N: request lines, sampled every cycle; a 1 sets the matching pending bit.
- `mask`  in  N: 1 = input ineligible for selection; its pending bit is still retained.
- `mode`  in  1: 0 = fixed priority, highest index wins; 1 = round-robin.
- `ack`  in  1: consumer acknowledge; meaningful only while `grant_valid`=1.
- `grant_id`  out  IDW: registered index of the granted input.
- `grant_valid`  out  1: registered; 1 while a grant is outstanding.
- `pending`  out  N: registered pending vector.

## Operation
- Reset values:
  - `pending`=0, `grant_id`=0, `grant_valid`=0.
  - Internal state = IDLE.
  - Round-robin pointer `last`=0.
- Pending update every cycle: `pending <= (pending & ~clr) | req`.
  - `clr` is one-hot at `grant_id` when an ack is accepted, else 0.
  - Set wins: if `req[grant_id]`=1 in the ack cycle, the bit stays 1.
- Eligible vector: `elig = pending & ~mask`.
- State IDLE:
  - If `elig`≠0: register the winner into `grant_id`, set `grant_valid`=1, go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - `grant_id` is held stable and is not re-arbitrated, even if `mask`, `mode` or `pending` change.
  - On `ack`=1: clear `pending[grant_id]`, set `last <= grant_id`, `grant_valid <= 0`, go to IDLE.
- Fixed mode: the winner is the highest set index of `elig`.
- Round-robin mode:
  - Scan order is `last-1, last-2, …, 0, N-1, …, last`, descending with wrap modulo N.
  - The first eligible index in that order wins, so the input just served has the lowest priority.
  - With `last`=0 the order equals fixed mode.
- `last` is updated on every accepted ack in both modes, so switching modes takes effect cleanly at the next selection.
- `ack` while in IDLE is ignored, with no state change.
- Masked pending bits never win, but they remain set and are granted once unmasked.

## Timing
- Request to grant latency:
  - `req[i]` high in cycle 0 → `pending[i]`=1 after edge 1.
  - → `grant_valid`=1, `grant_id`=i after edge 2.
- Acknowledge:
  - `ack` sampled in cycle k → `grant_valid`=0 and `pending` bit cleared after edge k+1.
  - The earliest next `grant_valid`=1 is after edge k+2: one mandatory IDLE cycle between grants.
- Throughput: at most one grant per 2 cycles when `ack` is returned in the first grant cycle.
- `ack` in the same cycle `grant_valid` first rises is legal and accepted.
- `rst_n` asserted mid-grant:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The outstanding grant is dropped and no ack is required.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/include (`prio_pkg`) contains:
  - The state encodings, `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1.
  - The `clog2` helper used for `IDW`.
- One sub-module, `prio_pick`: purely combinational.
  - Inputs: `vec[N-1:0]` and start index `start[IDW-1:0]`.
  - Outputs: `idx[IDW-1:0]` and `found`.
  - It implements the descending, wrapping scan.
  - Fixed mode uses it with `start = N-1`; round-robin mode uses it with `start = (last-1) mod N`.
- Top-level: pending register, FSM, `last` pointer, and output registers.

## Test plan
- Reset and basic grant (N=8, mode=0):
  - Release `rst_n`; all outputs read 0.
  - Pulse `req`=8'b0010_0100 for 1 cycle → two edges later `grant_id`=5, `grant_valid`=1, `pending`=8'b0010_0100.
  - `ack` → `pending`=8'b0000_0100; after the IDLE cycle `grant_id`=2.
- Fixed priority with masking:
  - `pending` bits 7,3 set with `mask`=8'h80 → `grant_id`=3.
  - After ack, clear the mask → `grant_id`=7.
- Round-robin fairness:
  - mode=1, `req`=8'b1000_0011 held continuously, `ack` every grant → grants cycle 7,1,0,7,1,0.
  - Under mode=0 the same stimulus gives 7,7,7.
- Set-wins and hold:
  - `ack` in the same cycle as `req[grant_id]`=1 → the pending bit stays 1 and the same index is regranted.
  - Changing `mask` to hide `grant_id` during GRANT does not change `grant_id`.
- Boundaries:
  - N=5: round-robin with `last`=0 wraps to index 4.
  - `ack` in IDLE causes no change.
  - `rst_n` asserted during GRANT → `grant_valid`=0 and `pending`=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared definitions for the priority interrupt arbiter: FSM encodings and
// the width helper used to size grant indices.
package prio_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } prio_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Descending, wrapping priority scan: first set bit of vec found walking
// start, start-1, ..., 0, N-1, ... wins.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N   = 8,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] start,
  output logic [IDW-1:0] idx,
  output logic           found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // start < N always, so the +N keeps the modulo operand non-negative
    for (int k = 0; k < N; k++) begin
      if (!found && vec[(int'(start) + N - k) % N]) begin
        idx   = IDW'((int'(start) + N - k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_irq_arbiter.sv
// Registered N-input priority arbiter: pending latches, per-input masking,
// fixed or round-robin selection, grant held until acknowledged.
module prio_irq_arbiter
  import prio_pkg::*;
#(
  parameter int N   = 8,
  parameter int IDW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic           mode,
  input  logic           ack,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic [N-1:0]   pending
);

  prio_st_e       st, st_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] rr_start, pick_start, pick_idx;
  logic           pick_found;
  logic           ack_acc;
  logic [N-1:0]   elig, clr;

  assign elig     = pending & ~mask;
  // Input just served gets lowest priority: scan starts one below it.
  assign rr_start = (last == '0) ? IDW'(N - 1) : last - IDW'(1);

  always_comb begin
    st_nxt     = st;
    ack_acc    = 1'b0;
    clr        = '0;
    pick_start = mode ? rr_start : IDW'(N - 1);
    case (st)
      ST_IDLE:  if (|elig) st_nxt = ST_GRANT;
      ST_GRANT: if (ack) begin
        st_nxt  = ST_IDLE;
        ack_acc = 1'b1;
      end
    endcase
    if (ack_acc) clr[grant_id] = 1'b1;
  end

  prio_pick #(.N(N), .IDW(IDW)) u_pick (
    .vec   (elig),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      pending     <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      last        <= '0;
    end else begin
      // Set wins over the ack clear
      pending <= (pending & ~clr) | req;
      st      <= st_nxt;
      if (st == ST_IDLE && pick_found) begin
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
      end
      if (ack_acc) begin
        last        <= grant_id;
        grant_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_irq_arbiter.sv
// Directed checks for prio_irq_arbiter at N=8 and N=5.
module tb_prio_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask;
  logic       mode, ack;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic [7:0] pending;

  logic [4:0] req5, mask5;
  logic       mode5, ack5;
  logic [2:0] grant_id5;
  logic       grant_valid5;
  logic [4:0] pending5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_irq_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .mode(mode), .ack(ack),
    .grant_id(grant_id), .grant_valid(grant_valid), .pending(pending)
  );

  prio_irq_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mask(mask5), .mode(mode5), .ack(ack5),
    .grant_id(grant_id5), .grant_valid(grant_valid5), .pending(pending5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rr_exp [6];
    rr_exp = '{7, 1, 0, 7, 1, 0};
    rst_n = 1'b0;
    req = '0; mask = '0; mode = 1'b0; ack = 1'b0;
    req5 = '0; mask5 = '0; mode5 = 1'b0; ack5 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_pending", pending, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);

    // basic fixed-priority grant
    req = 8'b0010_0100;
    tick();
    req = '0;
    chk("basic_pend1", pending, 8'h24);
    chk("basic_gv1", grant_valid, 0);
    tick();
    chk("basic_gid5", grant_id, 5);
    chk("basic_gv2", grant_valid, 1);
    chk("basic_pend2", pending, 8'h24);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("basic_pend3", pending, 8'h04);
    chk("basic_gv3", grant_valid, 0);
    tick();
    chk("basic_gid2", grant_id, 2);
    chk("basic_gv4", grant_valid, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("basic_pend4", pending, 0);

    // ack in IDLE is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_gv", grant_valid, 0);
    chk("idle_ack_pend", pending, 0);
    chk("idle_ack_gid", grant_id, 2);

    // masking, and mask change during GRANT does not re-arbitrate
    mask = 8'h80;
    req  = 8'h88;
    tick();
    req = '0;
    tick();
    chk("mask_gid3", grant_id, 3);
    chk("mask_gv", grant_valid, 1);
    mask = 8'h88;
    tick();
    chk("hold_gid3", grant_id, 3);
    chk("hold_gv", grant_valid, 1);
    ack  = 1'b1;
    mask = '0;
    tick();
    ack = 1'b0;
    chk("mask_pend", pending, 8'h80);
    tick();
    chk("unmask_gid7", grant_id, 7);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("unmask_pend", pending, 0);

    // fresh reset so round-robin starts from last=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 1'b1;
    req  = 8'b1000_0011;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_gid[%0d]", i), grant_id, rr_exp[i]);
      chk($sformatf("rr_gv[%0d]", i), grant_valid, 1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk($sformatf("rr_setwins[%0d]", i), pending, 8'h83);
      tick();
    end

    // fixed mode, same stimulus: highest index every time
    mode = 1'b0;
    chk("fix_hold_gid", grant_id, 7);
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      chk($sformatf("fix_gid[%0d]", i), grant_id, 7);
    end

    // asynchronous reset mid-grant
    chk("pre_rst_gv", grant_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_gv", grant_valid, 0);
    chk("arst_pend", pending, 0);
    chk("arst_gid", grant_id, 0);
    req = '0;
    tick();
    rst_n = 1'b1;

    // N=5 round-robin wrap from last=0
    mode5 = 1'b1;
    req5  = 5'b10001;
    tick();
    req5 = '0;
    chk("n5_pend", pending5, 5'h11);
    tick();
    chk("n5_gid4", grant_id5, 4);
    chk("n5_gv", grant_valid5, 1);
    ack5 = 1'b1;
    tick();
    ack5 = 1'b0;
    tick();
    chk("n5_gid0", grant_id5, 0);
    ack5 = 1'b1;
    tick();
    ack5 = 1'b0;
    chk("n5_pend_end", pending5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
